// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and command codes for the SPI master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      WAIT_RD,
      READ,
      GAP
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shreg.sv
// spi_shreg: parallel-load, MSB-first shift register; serial out on the MSB, serial in on the LSB.
// Latency: load or shift takes effect on the next rising edge.
// Backpressure: none; load has priority over shift.
module spi_shreg #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift,
   input  logic         sin,
   output logic         sout,
   output logic [W-1:0] q
);

   // Load a whole frame, or move one bit towards the MSB taking sin at the LSB.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {q[W-2:0], sin};
      end
   end

   assign sout = q[W-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: turns {cmd,data} requests into SS_n-framed MOSI frames; RD_DATA collects an 8-bit MISO reply.
// Latency: SS_n falls 1 clk after accept; rd_valid pulses in the first SS_n-high cycle after the last MISO bit.
// Backpressure: req_ready only in IDLE; the IDLE cycle is the last of the GAP_CYCLES SS_n-high cycles. Option: SPI_MASTER_ABORT_EN.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int RD_WAIT    = 1,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_cmd,
   input  logic [DATA_W-1:0] req_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              SS_n,
   output logic              MOSI,
`ifdef SPI_MASTER_ABORT_EN
   input  logic              abort,
`endif
   input  logic              MISO
);

   localparam int FRAME_W = DATA_W + 2;
   // The accepting IDLE cycle already keeps SS_n high, so GAP covers the rest.
   localparam int GAP_LEN = GAP_CYCLES - 1;
   localparam int GAP_LD  = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;
   localparam int WAIT_LD = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;
   localparam int CNT_W   = $clog2(FRAME_W + RD_WAIT + GAP_CYCLES + 1);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               is_rd;
   logic               sh_load, sh_shift, sh_out;
   logic [FRAME_W-1:0] sh_q;
   logic               frame_end, rd_done, abort_hit;
   logic               unused_hi;

   // The top frame bits are only ever shifted out, never read in parallel.
   assign unused_hi = ^sh_q[FRAME_W-1:DATA_W-1];

`ifdef SPI_MASTER_ABORT_EN
   assign abort_hit = abort && (state != IDLE) && (state != GAP);
`else
   assign abort_hit = 1'b0;
`endif

   spi_shreg #(.W(FRAME_W)) u_shreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sh_load),
      .load_val ({req_cmd, req_data}),
      .shift    (sh_shift),
      .sin      (MISO),
      .sout     (sh_out),
      .q        (sh_q)
   );

   // Next state, down-counter reload and shift-register control.
   always_comb begin
      state_nx  = state;
      cnt_nx    = (cnt != '0) ? cnt - 1'b1 : cnt;
      sh_load   = 1'b0;
      frame_end = 1'b0;
      rd_done   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_nx = SETUP;
               sh_load  = 1'b1;
            end
         end
         SETUP: begin
            state_nx = SHIFT;
            cnt_nx   = CNT_W'(FRAME_W - 1);
         end
         SHIFT: begin
            if (cnt == '0) begin
               if (!is_rd) begin
                  frame_end = 1'b1;
               end else if (RD_WAIT > 0) begin
                  state_nx = WAIT_RD;
                  cnt_nx   = CNT_W'(WAIT_LD);
               end else begin
                  state_nx = READ;
                  cnt_nx   = CNT_W'(DATA_W - 1);
               end
            end
         end
         WAIT_RD: begin
            if (cnt == '0) begin
               state_nx = READ;
               cnt_nx   = CNT_W'(DATA_W - 1);
            end
         end
         READ: begin
            if (cnt == '0) begin
               frame_end = 1'b1;
               rd_done   = 1'b1;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (abort_hit) begin
         frame_end = 1'b1;
         rd_done   = 1'b0;
      end
      if (frame_end) begin
         if (GAP_LEN > 0) begin
            state_nx = GAP;
            cnt_nx   = CNT_W'(GAP_LD);
         end else begin
            state_nx = IDLE;
         end
      end
      sh_shift = (state_nx == SHIFT) || (state == READ && !abort_hit);
   end

   // State, counter and every output are registered from the next-state decode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         is_rd     <= 1'b0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         if (sh_load) begin
            is_rd <= (req_cmd == CMD_RD_DATA);
         end
         SS_n      <= (state_nx == IDLE) || (state_nx == GAP);
         MOSI      <= (state_nx == SHIFT) ? sh_out : 1'b0;
         req_ready <= (state_nx == IDLE);
         busy      <= (state_nx != IDLE);
         rd_valid  <= rd_done;
         if (rd_done) begin
            rd_data <= {sh_q[DATA_W-2:0], MISO};
         end
      end
   end

endmodule
